pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the five-stage ARM core. It drives the freeze and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three cases: read-after-write hazards on ID source registers, taken branches resolved in EXE, and multi-cycle data-memory accesses. It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

## Interface
- MAX_WAIT, 64, memory wait cycles before `mem_timeout` sets
- CNT_W, 16, width of the performance counters
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- src1, src2  in  4  ID-stage source register indices
- two_src  in  1  ID instruction reads src2
- id_valid  in  1  ID holds a real instruction that reads src1
- exe_wb_en, mem_wb_en  in  1  EXE / MEM instruction writes back
- exe_dest, mem_dest  in  4  EXE / MEM destination register
- exe_mem_read  in  1  EXE instruction is a load
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM stage holds a load/store
- mem_ready  in  1  data memory completes the access this cycle
- pc_freeze, if_id_freeze  out  1  hold PC and IF/ID
- if_id_flush, id_ex_flush  out  1  clear IF/ID and ID/EX to a bubble
- id_ex_freeze, ex_mem_freeze  out  1  hold ID/EX and EX/MEM
- mem_wb_bubble  out  1  MEM/WB captures wb_en=0
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters
- mem_timeout  out  1  sticky; set when a wait reaches MAX_WAIT

## Operation
- FSM states: RUN, MEM_WAIT, BR_PEND.
- RUN → MEM_WAIT when `mem_req && !mem_ready`.
  - In that cycle assert all four freezes and `mem_wb_bubble`.
- MEM_WAIT:
  - Same freezes and `mem_wb_bubble` every cycle while `!mem_ready`.
  - On `mem_ready`, drop all freezes in that cycle.
  - Go to RUN, or to BR_PEND if a branch was latched.
- `branch_taken` seen while frozen is latched into `br_latch`.
  - It is acted on in the first unfrozen cycle (BR_PEND, or RUN when no latch is set).
  - Taken-branch action: `if_id_flush=1`, `id_ex_flush=1`.
  - BR_PEND → RUN after one cycle.
- Priority, highest first: memory stall, then branch flush, then hazard stall.
  - A hazard is ignored in any cycle that flushes IF/ID.
- hazard (RUN only):
  - `pc_freeze=1`, `if_id_freeze=1`, `id_ex_flush=1`.
  - No next-state change; re-evaluated every cycle.
- Hazard compare:
  - Source matches are qualified by `id_valid`.
  - src2 matches are also qualified by `two_src`.
  - Producer matches are qualified by the matching `*_wb_en`.
- Counters:
  - `stall_cnt` +1 per cycle with `pc_freeze` high.
  - `flush_cnt` +1 per cycle with `if_id_flush` high.
  - Both saturate at all-ones.
- Wait counter:
  - Counts MEM_WAIT cycles and clears on exit.
  - Reaching MAX_WAIT sets `mem_timeout`; the FSM keeps waiting.
  - `mem_timeout` clears only on reset.

## Timing
- Control outputs are combinational from the registered state and current inputs: zero latency into the pipeline registers.
- State, `br_latch`, counters and `mem_timeout` update on the rising `clk` edge.
- Reset (`rst` low at the edge):
  - State → RUN.
  - `br_latch`, `stall_cnt`, `flush_cnt`, wait counter and `mem_timeout` → 0.
  - While `rst` is low: all freezes and `mem_wb_bubble` = 0, both flushes = 1.
- Reset during MEM_WAIT abandons the access; the next cycle is RUN.
- `mem_req && mem_ready` in the same RUN cycle: no stall.
- `branch_taken` and hazard in the same cycle: flush only, no freeze.
- `branch_taken` and a `mem_ready` release in the same cycle: flush in that cycle, no BR_PEND.

## Configuration
- `PIPE_CTRL_FORWARDING_EN` defined:
  - hazard = `exe_mem_read && exe_wb_en` and `exe_dest` matches src1/src2 (load-use only).
  - MEM-stage producers are forwarded, so they never stall.
- Undefined:
  - hazard = any qualified match against (`exe_wb_en`, `exe_dest`) or (`mem_wb_en`, `mem_dest`).

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MEM_WAIT, BR_PEND);
  - the register-index width constant (4);
  - the default MAX_WAIT and CNT_W values.
- Sub-module `hazard_detect`: combinational source/destination compare, including the `PIPE_CTRL_FORWARDING_EN` variant.
- Top level holds the FSM, branch latch and counters.

## Test plan
- Hazard, forwarding undefined:
  - Stimulus: `src1=3`, `id_valid=1`, `exe_wb_en=1`, `exe_dest=3`.
  - Response: `pc_freeze=if_id_freeze=id_ex_flush=1`; `stall_cnt` 0→1.
  - Stimulus: move the producer to MEM (`mem_dest=3`, `mem_wb_en=1`, no EXE match).
  - Response: same stall.
- Forwarding defined:
  - Stimulus: `mem_dest=3`, `mem_wb_en=1`, no load in EXE.
  - Response: no stall.
  - Stimulus: `exe_mem_read=1`, `exe_dest=3`, `exe_wb_en=1`.
  - Response: stall for exactly 1 cycle.
- Taken branch:
  - Stimulus: `branch_taken=1`, with a concurrent src2 match and `two_src=1`.
  - Response: both flushes = 1, `pc_freeze=0`; `flush_cnt=1`.
- Memory wait:
  - Stimulus: `mem_req=1`, `mem_ready` low for 3 cycles then high.
  - Response: all four freezes plus `mem_wb_bubble` for 3 cycles; all clear in the ready cycle; `stall_cnt=3`.
- Branch during memory wait:
  - Stimulus: `branch_taken` pulses in MEM_WAIT cycle 2.
  - Response: no flush while frozen; after release, state is BR_PEND and one cycle of both flushes follows.
- Timeout and reset:
  - Stimulus: MAX_WAIT=4, `mem_ready` held low.
  - Response: `mem_timeout=1` after the 4th wait cycle.
  - Stimulus: `rst` low for one edge.
  - Response: flag and counters return to 0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Register index width of the ARM core (r0..r15)
    localparam int REG_W        = 4;
    localparam int MAX_WAIT_DEF = 64;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_PEND  = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Read-after-write hazard compare between ID sources and EXE/MEM destinations.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result only requests a stall from the controller.
// Build option: PIPE_CTRL_FORWARDING_EN restricts hazards to EXE load-use.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic             id_valid,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_mem_read,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    output logic             hazard
);

    logic exe_hit;
    logic mem_hit;

    // A source only counts when the ID instruction really reads it
    assign exe_hit = (id_valid && (src1 == exe_dest)) ||
                     (id_valid && two_src && (src2 == exe_dest));
    assign mem_hit = (id_valid && (src1 == mem_dest)) ||
                     (id_valid && two_src && (src2 == mem_dest));

`ifdef PIPE_CTRL_FORWARDING_EN
    // MEM and non-load EXE results are forwarded; only a load in EXE stalls
    logic unused_mem_hit;
    assign unused_mem_hit = mem_hit ^ mem_wb_en;
    assign hazard = exe_mem_read && exe_wb_en && exe_hit;
`else
    // No bypass network: any pending writer of a source stalls
    logic unused_exe_mem_read;
    assign unused_exe_mem_read = exe_mem_read;
    assign hazard = (exe_wb_en && exe_hit) || (mem_wb_en && mem_hit);
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Freeze/flush sequencing for the 5-stage pipe: memory stall > branch flush > RAW stall.
// Latency: control outputs are combinational (zero cycles); state/counters update on clk.
// Backpressure: a data-memory wait freezes PC..EX/MEM and bubbles MEM/WB until mem_ready.
// Build option: PIPE_CTRL_FORWARDING_EN selects load-use-only hazard detection.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic             id_valid,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             exe_mem_read,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_freeze,
    output logic             ex_mem_freeze,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state;
    state_t            state_nxt;
    logic              br_latch;
    logic              br_latch_nxt;
    logic              hazard;
    logic              mem_stall;
    logic              br_flush;
    logic [WAIT_W-1:0] wait_cnt;

    hazard_detect u_hazard (
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .id_valid     (id_valid),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .exe_mem_read (exe_mem_read),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .hazard       (hazard)
    );

    // Next state and pipeline controls, resolved in priority order
    always_comb begin
        state_nxt     = state;
        br_latch_nxt  = br_latch;
        mem_stall     = 1'b0;
        br_flush      = 1'b0;
        pc_freeze     = 1'b0;
        if_id_freeze  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        id_ex_freeze  = 1'b0;
        ex_mem_freeze = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            // Flush IF/ID and ID/EX so the pipe restarts from bubbles
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            state_nxt    = RUN;
            br_latch_nxt = 1'b0;
        end else begin
            if (state == MEM_WAIT) mem_stall = !mem_ready;
            else                   mem_stall = mem_req && !mem_ready;

            if (mem_stall) begin
                pc_freeze     = 1'b1;
                if_id_freeze  = 1'b1;
                id_ex_freeze  = 1'b1;
                ex_mem_freeze = 1'b1;
                mem_wb_bubble = 1'b1;
                state_nxt     = MEM_WAIT;
                // A branch resolved while frozen is replayed after release
                if (branch_taken) br_latch_nxt = 1'b1;
            end else begin
                br_flush = branch_taken || (state == BR_PEND);
                case (state)
                    MEM_WAIT: state_nxt = br_latch ? BR_PEND : RUN;
                    BR_PEND: begin
                        state_nxt    = RUN;
                        br_latch_nxt = 1'b0;
                    end
                    default:  state_nxt = RUN;
                endcase
                if (br_flush) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if ((state == RUN) && hazard) begin
                    pc_freeze    = 1'b1;
                    if_id_freeze = 1'b1;
                    id_ex_flush  = 1'b1;
                end
            end
        end
    end

    // FSM state and latched branch
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            br_latch <= 1'b0;
        end else begin
            state    <= state_nxt;
            br_latch <= br_latch_nxt;
        end
    end

    // Saturating stall / flush performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_freeze && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
            if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Memory wait length and sticky timeout; the FSM keeps waiting regardless
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if ((state == MEM_WAIT) && !mem_ready) begin
            if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_W'(MAX_WAIT - 1)) mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule
